vga_pixel_pipe: RTL and testbench

Parametrised VGA timing and pixel output stage that replaces the fixed 640x480 sync generator and its single RGB register at the top of each video design. It generates the pixel-clock enable, pixel coordinates and sync timing from one system clock. It also delay-matches hsync/vsync/blanking to a graphics generator with a configurable pipeline depth, and drives a registered, blanked RGB output. Graphics blocks (pong, text, bitmap) connect between `pixel_x`/`pixel_y` and `rgb_in`.

---
 rtl/vga_pixel_pipe.sv | 158 +++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: parametrised VGA timing generator and registered pixel output stage.
// Produces the pixel-clock enable, pixel coordinates and sync timing from one system clock,
// delay-matches sync/blank to a PIPE-tick graphics generator and drives blanked RGB.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output and counter.
module vga_pixel_pipe #(
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned DIV      = 2,
  parameter int unsigned PIPE     = 0,
  parameter int unsigned RGB_W    = 3,
  parameter int unsigned CW       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CW-1:0]    pixel_x,
  output logic [CW-1:0]    pixel_y,
  output logic             video_on,
  output logic             p_tick,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic [RGB_W-1:0] rgb
);

  localparam int unsigned HTotal = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] HLast    = CW'(HTotal - 1);
  localparam logic [CW-1:0] VLast    = CW'(VTotal - 1);
  localparam logic [CW-1:0] HDispEnd = CW'(H_DISP);
  localparam logic [CW-1:0] VDispEnd = CW'(V_DISP);
  localparam logic [CW-1:0] HsStart  = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HsEnd    = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VsStart  = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VsEnd    = CW'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic [3:0]    DivLast  = 4'(DIV - 1);
  localparam logic          SyncAct  = (SYNC_POL != 0);

  // A zero-depth pipe still needs a legal array; it is bypassed below.
  localparam int unsigned PipeDepth = (PIPE == 0) ? 1 : PIPE;

  logic [3:0]    div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          h_last, v_last;
  logic          h_act, v_act;

  // Per-stage bundle: {h_act, v_act, video_on}.
  logic [2:0]    pipe_q [PipeDepth];
  logic [2:0]    raw_ctl, dly_ctl;

  logic [RGB_W-1:0] rgb_q;
  logic             hsync_q, vsync_q;

  // Pixel-clock divider next state.
  always_comb begin
    div_d = div_q + 4'd1;
    if (div_q == DivLast) div_d = '0;
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign p_tick = (div_q == DivLast) && !reset;

  assign h_last = (h_q == HLast);
  assign v_last = (v_q == VLast);

  // Horizontal/vertical counter next state; both wrap together at end of frame.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (p_tick) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Coordinate counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign frame_start = p_tick && h_last && v_last;

  assign h_act    = (h_q >= HsStart) && (h_q <= HsEnd);
  assign v_act    = (v_q >= VsStart) && (v_q <= VsEnd);
  assign video_on = (h_q < HDispEnd) && (v_q < VDispEnd);
  assign raw_ctl  = {h_act, v_act, video_on};

  // Alignment shift register matching the graphics generator latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(PipeDepth); i++) pipe_q[i] <= 3'b000;
    end else if (p_tick) begin
      pipe_q[0] <= raw_ctl;
      for (int i = 1; i < int'(PipeDepth); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dly_ctl = (PIPE == 0) ? raw_ctl : pipe_q[PipeDepth-1];

  // Output register: blanked colour and sync at the configured active level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= ~SyncAct;
      vsync_q <= ~SyncAct;
    end else if (p_tick) begin
      rgb_q   <= dly_ctl[0] ? rgb_in : '0;
      hsync_q <= ~(dly_ctl[2] ^ SyncAct);
      vsync_q <= ~(dly_ctl[1] ^ SyncAct);
    end
  end

  assign rgb   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Free-running frame counter for animation timing; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)            frame_cnt_q <= '0;
    else if (frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: two instances with reduced timing so full frames fit in a short run.
// Instance A: DIV=2, PIPE=0, active-low sync. Instance B: DIV=1, PIPE=2, active-high sync.
module tb_vga_pixel_pipe;

  localparam int HD = 20, HF = 4, HS = 6, HB = 5, HT = HD + HF + HS + HB;
  localparam int VD = 10, VF = 2, VS = 2, VB = 3, VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk;
  logic reset;
  logic [2:0] rgb_in_a, rgb_in_b;
  logic [9:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
  logic video_on_a, p_tick_a, frame_start_a, hsync_a, vsync_a;
  logic video_on_b, p_tick_b, frame_start_b, hsync_b, vsync_b;
  logic [2:0] rgb_a, rgb_b;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_a, frame_cnt_b;
`endif

  vga_pixel_pipe #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .DIV(2), .PIPE(0), .RGB_W(3), .CW(10)
  ) u_dut_a (
    .clk(clk), .reset(reset), .rgb_in(rgb_in_a),
    .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .video_on(video_on_a),
    .p_tick(p_tick_a), .frame_start(frame_start_a),
    .hsync(hsync_a), .vsync(vsync_a),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(frame_cnt_a),
`endif
    .rgb(rgb_a)
  );

  vga_pixel_pipe #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1), .DIV(1), .PIPE(2), .RGB_W(3), .CW(10)
  ) u_dut_b (
    .clk(clk), .reset(reset), .rgb_in(rgb_in_b),
    .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .video_on(video_on_b),
    .p_tick(p_tick_b), .frame_start(frame_start_b),
    .hsync(hsync_b), .vsync(vsync_b),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(frame_cnt_b),
`endif
    .rgb(rgb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;
  int e;                       // clk edges since the last edge that sampled reset
  logic [2:0] hist_a [8192];   // rgb_in_a value presented on each tick of A
  bit use_force;
  logic [2:0] force_val;

  typedef struct {
    int x; int y; int rgb; int exp_rgb; int exp_hs; int exp_vs;
  } vec_t;
  vec_t tbl [13];

  // Screen geometry as plain arithmetic on a tick index since reset.
  function automatic int xof(int t); return t % HT; endfunction
  function automatic int yof(int t); return (t / HT) % VT; endfunction
  function automatic bit vid(int t); return xof(t) < HD && yof(t) < VD; endfunction
  function automatic bit hact(int t);
    return xof(t) >= HD + HF && xof(t) < HD + HF + HS;
  endfunction
  function automatic bit vact(int t);
    return yof(t) >= VD + VF && yof(t) < VD + VF + VS;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, e, $time);
    end
  endtask

  // Advance one clk, compare both instances against the model, choose next inputs.
  task automatic step();
    int na, nb, ka, kb;
    bit tick_a;
    @(posedge clk);
    #1;
    if (reset) e = 0;
    else       e++;
    na = e / 2;
    nb = e;
    tick_a = (e % 2 == 1);

    chk("p_tick_a", p_tick_a, !reset && tick_a);
    chk("p_tick_b", p_tick_b, !reset);
    chk("pixel_x_a", pixel_x_a, xof(na));
    chk("pixel_y_a", pixel_y_a, yof(na));
    chk("pixel_x_b", pixel_x_b, xof(nb));
    chk("pixel_y_b", pixel_y_b, yof(nb));
    chk("video_on_a", video_on_a, vid(na));
    chk("video_on_b", video_on_b, vid(nb));
    chk("frame_start_a", frame_start_a, !reset && tick_a && (na % FRAME == FRAME - 1));
    chk("frame_start_b", frame_start_b, !reset && (nb % FRAME == FRAME - 1));

    ka = na - 1;
    chk("rgb_a", rgb_a, (ka >= 0 && vid(ka)) ? hist_a[ka % 8192] : 3'd0);
    chk("hsync_a", hsync_a, (ka >= 0 && hact(ka)) ? 0 : 1);
    chk("vsync_a", vsync_a, (ka >= 0 && vact(ka)) ? 0 : 1);

    kb = nb - 3;
    chk("rgb_b", rgb_b, (kb >= 0 && vid(kb)) ? xof(kb) % 8 : 0);
    chk("hsync_b", hsync_b, (kb >= 0 && hact(kb)) ? 1 : 0);
    chk("vsync_b", vsync_b, (kb >= 0 && vact(kb)) ? 1 : 0);
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt_a", frame_cnt_a, (na / FRAME) % 65536);
    chk("frame_cnt_b", frame_cnt_b, (nb / FRAME) % 65536);
`endif

    rgb_in_a = use_force ? force_val : 3'($urandom_range(0, 7));
    if (tick_a) hist_a[na % 8192] = rgb_in_a;
    rgb_in_b = (nb >= 2) ? 3'(xof(nb - 2) % 8) : 3'd0;
  endtask

  initial begin
    int budget, ticks;
    bit found;
    n_chk = 0; n_fail = 0; e = 0;
    use_force = 1'b0; force_val = 3'd0;
    reset = 1'b1; rgb_in_a = 3'd0; rgb_in_b = 3'd0;

    // {x, y, rgb_in at that tick, rgb / hsync / vsync one tick later} for instance A.
    tbl[0]  = '{0, 0, 7, 7, 1, 1};
    tbl[1]  = '{19, 0, 5, 5, 1, 1};
    tbl[2]  = '{20, 0, 7, 0, 1, 1};
    tbl[3]  = '{23, 1, 7, 0, 1, 1};
    tbl[4]  = '{24, 1, 7, 0, 0, 1};
    tbl[5]  = '{29, 1, 3, 0, 0, 1};
    tbl[6]  = '{30, 1, 7, 0, 1, 1};
    tbl[7]  = '{19, 9, 6, 6, 1, 1};
    tbl[8]  = '{34, 9, 7, 0, 1, 1};
    tbl[9]  = '{0, 10, 7, 0, 1, 1};
    tbl[10] = '{5, 12, 7, 0, 1, 0};
    tbl[11] = '{26, 13, 7, 0, 0, 0};
    tbl[12] = '{5, 14, 7, 0, 1, 1};

    repeat (5) step();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      budget = 4 * FRAME;
      use_force = 1'b1;
      force_val = 3'(tbl[i].rgb);
      do begin
        step();
        budget--;
        found = p_tick_a && (int'(pixel_x_a) == tbl[i].x) && (int'(pixel_y_a) == tbl[i].y);
      end while (!found && budget > 0);
      chk("vec_reached", found, 1);
      step();
      chk("vec_rgb", rgb_a, tbl[i].exp_rgb);
      chk("vec_hsync", hsync_a, tbl[i].exp_hs);
      chk("vec_vsync", vsync_a, tbl[i].exp_vs);
    end
    use_force = 1'b0;

    // Random colour across two more frames, covering the frame wrap.
    repeat (4 * FRAME) step();

    // Mid-frame reset at A coordinate (15,6).
    budget = 4 * FRAME;
    do begin
      step();
      budget--;
      found = p_tick_a && pixel_x_a == 10'd15 && pixel_y_a == 10'd6;
    end while (!found && budget > 0);
    chk("rst_point_reached", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_x_a", pixel_x_a, 0);
    chk("rst_y_a", pixel_y_a, 0);
    chk("rst_rgb_a", rgb_a, 0);
    chk("rst_hsync_a", hsync_a, 1);
    chk("rst_vsync_a", vsync_a, 1);
    chk("rst_hsync_b", hsync_b, 0);
    chk("rst_vsync_b", vsync_b, 0);

    // Next frame_start must come exactly one frame of ticks after reset.
    ticks = 0;
    found = 1'b0;
    budget = 4 * FRAME;
    while (!found && budget > 0) begin
      step();
      budget--;
      if (p_tick_a) ticks++;
      if (frame_start_a) found = 1'b1;
    end
    chk("frame_start_seen", found, 1);
    chk("frame_period_ticks", ticks, FRAME);

    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
